// File: rtl/lut8_pkg.sv
// lut8_pkg: shared width, scheduler state encoding and the 8-input LUT function.
package lut8_pkg;

    localparam int VEC_W = 8;

    typedef enum logic [1:0] {ARB, DRAIN, SWEEP, FIN} state_t;

    // Operand bit 7 is a and bit 0 is h.
    function automatic logic lut8_fn(input logic [VEC_W-1:0] v);
        return (v[7] & v[6]) | (v[5] ^ (v[4] & v[3])) | (v[2] ^ (v[1] & v[0]));
    endfunction

endpackage

// File: rtl/lut8_rr_arbiter.sv
// lut8_rr_arbiter: round-robin one-hot grant; the search starts at ptr and wraps.
module lut8_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant = '0;
        sel   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        if (found) begin
            grant[sel] = 1'b1;
        end
    end

    // advance only rises on a real transfer, so sel is the winner here.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        end
    end

endmodule

// File: rtl/lut8_eval_scheduler.sv
// lut8_eval_scheduler: round-robin shared two-stage evaluator of the 8-input LUT function.
// Defining LUT8_SWEEP_EN adds a self-sweep of all 256 vectors that counts the ones.
module lut8_eval_scheduler
    import lut8_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*VEC_W-1:0]   req_vec,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_y,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       busy
`ifdef LUT8_SWEEP_EN
    ,
    input  logic                       sweep_start,
    output logic                       sweep_done,
    output logic [8:0]                 sweep_count
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [VEC_W-1:0] s1_vec;
    logic [ID_W-1:0]  s1_id;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_vld;
    logic             s1_swp;
    logic             s2_y;
    logic [ID_W-1:0]  s2_id;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_vld;
    logic             s2_swp;

    logic [NUM_REQ-1:0] grant;
    logic               adv;
    logic               in_arb;
    logic               inject;
    logic               take;
    logic [VEC_W-1:0]   take_vec;
    logic [TAG_W-1:0]   take_tag;
    logic [ID_W-1:0]    take_id;
    logic [VEC_W-1:0]   sweep_vec;

    // Sweep results never reach the consumer, so they must not stall on rsp_ready.
    assign adv       = !(s2_vld && !s2_swp) || rsp_ready;
    assign req_ready = grant & {NUM_REQ{adv & in_arb}};
    assign take      = |(req_valid & req_ready);

    assign rsp_valid = s2_vld & ~s2_swp;
    assign rsp_y     = s2_y;
    assign rsp_id    = s2_id;
    assign rsp_tag   = s2_tag;

    always_comb begin
        take_vec = '0;
        take_tag = '0;
        take_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                take_vec = req_vec[i*VEC_W +: VEC_W];
                take_tag = req_tag[i*TAG_W +: TAG_W];
                take_id  = ID_W'(i);
            end
        end
    end

    lut8_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (take),
        .grant   (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vec <= '0;
            s1_id  <= '0;
            s1_tag <= '0;
            s1_vld <= 1'b0;
            s1_swp <= 1'b0;
            s2_y   <= 1'b0;
            s2_id  <= '0;
            s2_tag <= '0;
            s2_vld <= 1'b0;
            s2_swp <= 1'b0;
        end else if (adv) begin
            s2_y   <= lut8_fn(s1_vec);
            s2_id  <= s1_id;
            s2_tag <= s1_tag;
            s2_vld <= s1_vld;
            s2_swp <= s1_swp;
            if (inject) begin
                s1_vec <= sweep_vec;
                s1_id  <= '0;
                s1_tag <= '0;
                s1_vld <= 1'b1;
                s1_swp <= 1'b1;
            end else begin
                s1_vec <= take_vec;
                s1_id  <= take_id;
                s1_tag <= take_tag;
                s1_vld <= take;
                s1_swp <= 1'b0;
            end
        end
    end

`ifdef LUT8_SWEEP_EN
    state_t           state;
    logic [VEC_W-1:0] sweep_idx;

    // A start pulse blocks same-cycle grants so the drain begins from a stable pipe.
    assign in_arb    = (state == ARB) && !sweep_start;
    assign inject    = (state == SWEEP);
    assign sweep_vec = sweep_idx;
    assign busy      = s1_vld | s2_vld | (state != ARB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB;
            sweep_idx   <= '0;
            sweep_count <= '0;
            sweep_done  <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                ARB: if (sweep_start) state <= DRAIN;
                DRAIN: begin
                    if (!s1_vld && !s2_vld) begin
                        state       <= SWEEP;
                        sweep_idx   <= '0;
                        sweep_count <= '0;
                    end
                end
                SWEEP: begin
                    if (adv) begin
                        sweep_idx <= sweep_idx + 1'b1;
                        if (sweep_idx == '1) state <= FIN;
                    end
                end
                FIN: begin
                    if (!s1_vld && !s2_vld) begin
                        sweep_done <= 1'b1;
                        state      <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
            // Counted as the flagged operand leaves S1, so FIN only needs the pipe empty.
            if (adv && s1_vld && s1_swp) begin
                sweep_count <= sweep_count + 9'(lut8_fn(s1_vec));
            end
        end
    end
`else
    assign in_arb    = 1'b1;
    assign inject    = 1'b0;
    assign sweep_vec = '0;
    assign busy      = s1_vld | s2_vld;
`endif

endmodule

// File: tb/tb_lut8_eval_scheduler.sv
// tb_lut8_eval_scheduler: scoreboard bench for the shared LUT evaluator and its arbiter.
// Exercises the sweep only when LUT8_SWEEP_EN is defined.
module tb_lut8_eval_scheduler;
    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 4;

    typedef struct {
        logic       y;
        int         id;
        logic [3:0] tag;
        int         cyc;
        bit         lat;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*8-1:0]   req_vec = '0;
    logic [NUM_REQ*TAG_W-1:0] req_tag = '0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b1;
    logic                   rsp_y;
    logic [1:0]             rsp_id;
    logic [TAG_W-1:0]       rsp_tag;
    logic                   busy;
`ifdef LUT8_SWEEP_EN
    logic                   sweep_start = 1'b0;
    logic                   sweep_done;
    logic [8:0]             sweep_count;
`endif

    exp_t sb[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   model_ptr = 0;
    int   rsp_count = 0;
    int   done_cnt = 0;
    int   sweep_rsp_seen = 0;
    bit   lat_check = 1'b0;
    bit   in_sweep = 1'b0;

    lut8_eval_scheduler #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_vec     (req_vec),
        .req_tag     (req_tag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_y       (rsp_y),
        .rsp_id      (rsp_id),
        .rsp_tag     (rsp_tag),
        .busy        (busy)
`ifdef LUT8_SWEEP_EN
        ,
        .sweep_start (sweep_start),
        .sweep_done  (sweep_done),
        .sweep_count (sweep_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic modelY(input logic [7:0] v);
        logic a, b, c, d, e, f, g, h;
        {a, b, c, d, e, f, g, h} = v;
        return (a && b) || (c != (d && e)) || (f != (g && h));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Handshakes are observed mid-cycle, when DUT combinational outputs are settled.
    always @(negedge clk) begin : monitor
        int   exp_id;
        int   act_id;
        exp_t e;
        if (rst) begin
            sb.delete();
            model_ptr = 0;
        end else begin
            if ((req_valid & req_ready) != '0) begin
                exp_id = -1;
                act_id = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (exp_id < 0 && req_valid[(model_ptr + k) % NUM_REQ]) exp_id = (model_ptr + k) % NUM_REQ;
                    if (req_valid[k] && req_ready[k] && act_id < 0) act_id = k;
                end
                checkOutput("ready_onehot", 32'($countones(req_ready)), 32'd1);
                checkOutput("rr_grant", 32'(act_id), 32'(exp_id));
                e.y   = modelY(req_vec[exp_id*8 +: 8]);
                e.id  = exp_id;
                e.tag = req_tag[exp_id*TAG_W +: TAG_W];
                e.cyc = cyc;
                e.lat = lat_check;
                sb.push_back(e);
                grant_log.push_back(act_id);
                model_ptr = (exp_id + 1) % NUM_REQ;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                if (sb.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_y", 32'(rsp_y), 32'(e.y));
                    checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                    checkOutput("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                    if (e.lat) checkOutput("latency", 32'(cyc - e.cyc), 32'd2);
                end
            end
            if (in_sweep && rsp_valid) sweep_rsp_seen++;
        end
`ifdef LUT8_SWEEP_EN
        if (sweep_done) done_cnt++;
`endif
    end

    // Drives one request and holds it until the DUT accepts it.
    task automatic applyStimulus(input int id, input logic [7:0] vec, input logic [3:0] tag);
        int waited;
        waited = 0;
        req_valid[id] = 1'b1;
        req_vec[id*8 +: 8] = vec;
        req_tag[id*TAG_W +: TAG_W] = tag;
        @(negedge clk);
        while (!req_ready[id] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready[id]) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        checkOutput("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Holds reset across one sampling edge and checks every output while still in reset.
    task automatic resetAndCheck(input string name);
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, "_req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({name, "_rsp_y"}, 32'(rsp_y), 32'd0);
        checkOutput({name, "_rsp_id"}, 32'(rsp_id), 32'd0);
        checkOutput({name, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
`ifdef LUT8_SWEEP_EN
        checkOutput({name, "_sweep_done"}, 32'(sweep_done), 32'd0);
        checkOutput({name, "_sweep_count"}, 32'(sweep_count), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int saved_rsp;
        int waited;
        int done_before;
        logic [3:0] stall_tag;

        resetAndCheck("reset");

        // Single request, two-cycle latency.
        lat_check = 1'b1;
        applyStimulus(0, 8'hC0, 4'd3);
        waitDrain();

        // Back-to-back requests from one requester give consecutive results.
        applyStimulus(0, 8'h00, 4'd1);
        applyStimulus(0, 8'h18, 4'd2);
        applyStimulus(0, 8'h38, 4'd4);
        applyStimulus(0, 8'h06, 4'd5);
        waitDrain();
        checkOutput("b2b_rsp_count", 32'(rsp_count), 32'd5);
        lat_check = 1'b0;

        // All requesters contend for eight cycles from a fresh pointer.
        resetAndCheck("reset2");
        grant_log.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec[i*8 +: 8] = 8'(8'h11 * (i + 5));
            req_tag[i*TAG_W +: TAG_W] = 4'(i + 8);
        end
        req_valid = '1;
        repeat (8) @(posedge clk);
        #1;
        req_valid = '0;
        waitDrain();
        checkOutput("rr_log_size", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            checkOutput("rr_order", 32'(grant_log[i]), 32'(i % NUM_REQ));
        end

        // Backpressure with two requests in flight and a third waiting.
        saved_rsp = rsp_count;
        rsp_ready = 1'b0;
        applyStimulus(0, 8'hC0, 4'd5);
        applyStimulus(1, 8'h38, 4'd6);
        req_valid[2] = 1'b1;
        req_vec[2*8 +: 8] = 8'h06;
        req_tag[2*TAG_W +: TAG_W] = 4'd7;
        stall_tag = 4'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall_rsp_tag", 32'(rsp_tag), 32'(stall_tag));
            checkOutput("stall_rsp_id", 32'(rsp_id), 32'd0);
            checkOutput("stall_rsp_y", 32'(rsp_y), 32'd1);
            checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        applyStimulus(2, 8'h06, 4'd7);
        waitDrain();
        checkOutput("stall_rsp_count", 32'(rsp_count - saved_rsp), 32'd3);

        // Reset with the pipe full discards everything in flight.
        rsp_ready = 1'b0;
        applyStimulus(3, 8'hC0, 4'd9);
        applyStimulus(0, 8'h18, 4'd10);
        saved_rsp = rsp_count;
        resetAndCheck("reset_full");
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("reset_full_no_rsp", 32'(rsp_count - saved_rsp), 32'd0);

`ifdef LUT8_SWEEP_EN
        // Full sweep from idle.
        done_before = done_cnt;
        sweep_start = 1'b1;
        @(posedge clk);
        #1;
        sweep_start = 1'b0;
        in_sweep = 1'b1;
        @(negedge clk);
        checkOutput("sweep_busy", 32'(busy), 32'd1);
        waited = 0;
        while (!sweep_done && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("sweep_done_seen", 32'(sweep_done), 32'd1);
        checkOutput("sweep_count", 32'(sweep_count), 32'd208);
        @(negedge clk);
        checkOutput("sweep_done_pulse", 32'(sweep_done), 32'd0);
        checkOutput("sweep_count_hold", 32'(sweep_count), 32'd208);
        checkOutput("sweep_done_cnt", 32'(done_cnt - done_before), 32'd1);
        in_sweep = 1'b0;
        checkOutput("sweep_no_rsp", 32'(sweep_rsp_seen), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a sweep aborts it silently.
        sweep_start = 1'b1;
        @(posedge clk);
        #1;
        sweep_start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        done_before = done_cnt;
        resetAndCheck("reset_sweep");
        repeat (300) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 32'(done_cnt - done_before), 32'd0);
        checkOutput("abort_count", 32'(sweep_count), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
`endif

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
